bus_decoder: RTL and testbench

- Parametrised successor to the fixed two-way address decoder (memory at 0x00xxxxxx, LED/display at 0xffxxxxxx).
- Decodes address[31:24] against NUM_SLAVES tags and drives one-hot chip selects.
- Runs a per-access handshake with per-slave ready, muxing and registering read data back to the core.
- Unmapped addresses, illegal requests and slave timeouts raise a one-cycle bus_error; the block sits between maxicore32 and its peripherals.

---
 rtl/bus_decoder_pkg.sv | 27 ++
 rtl/bus_tag_match.sv | 32 +++
 rtl/bus_decoder.sv | 138 +++++++++++++
 tb/tb_bus_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_decoder_pkg.sv
// Shared definitions for the core-side bus decoder: FSM encoding, well-known
// slave tags and the bus data width.
package bus_decoder_pkg;

  localparam int DATA_WIDTH = 32;

  // Address[31:24] tags of the two original fixed slaves.
  localparam logic [7:0] MEMORY_TAG  = 8'h00;
  localparam logic [7:0] DISPLAY_TAG = 8'hff;

  // FSM state encoding.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_ACCESS = ACCESS,
    ST_ERROR  = ERROR
  } state_t;

  // Width of a slave index; a single slave still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_tag_match.sv
// Combinational tag comparator: finds the lowest-index slave whose tag equals
// the top address byte.
module bus_tag_match
  import bus_decoder_pkg::*;
#(
  parameter int                      NUM_SLAVES = 2,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_TAGS = {DISPLAY_TAG, MEMORY_TAG},
  localparam int                     SEL_W      = sel_width(NUM_SLAVES)
) (
  input  logic [7:0]       i_tag,
  output logic             o_hit,
  output logic [SEL_W-1:0] o_sel
);

  logic [NUM_SLAVES-1:0] w_match;

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_match
      assign w_match[gi] = (i_tag == SLAVE_TAGS[gi*8 +: 8]);
    end
  endgenerate

  // Priority select: scanning downward lets the lowest matching index win.
  always_comb begin
    o_hit = |w_match;
    o_sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) o_sel = SEL_W'(i);
    end
  end

endmodule

// File: rtl/bus_decoder.sv
// Address decoder between the core and its peripherals: decodes the top address
// byte into one-hot chip selects, runs the ready handshake with a timeout, and
// returns registered read data plus a one-cycle error pulse.
module bus_decoder
  import bus_decoder_pkg::*;
#(
  parameter int                      NUM_SLAVES     = 2,
  parameter logic [NUM_SLAVES*8-1:0] SLAVE_TAGS     = {DISPLAY_TAG, MEMORY_TAG},
  parameter int                      TIMEOUT_CYCLES = 16,
  parameter int                      COUNT_WIDTH    = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [29:0]                    address,
  input  logic                           read,
  input  logic                           write,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_data,
  input  logic [NUM_SLAVES-1:0]          slave_ready,
  output logic [NUM_SLAVES-1:0]          slave_cs,
  output logic [DATA_WIDTH-1:0]          data_in,
  output logic                           ready,
  output logic                           bus_error,
  output logic [COUNT_WIDTH-1:0]         error_count
);

  localparam int  SEL_W      = sel_width(NUM_SLAVES);
  localparam int  TW         = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

  state_t                  r_state;
  logic [SEL_W-1:0]        r_sel;
  logic                    r_is_read;
  logic [NUM_SLAVES-1:0]   r_cs;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_ready;
  logic                    r_bus_error;
  logic [COUNT_WIDTH-1:0]  r_err_count;
  logic [TW-1:0]           r_timer;

  logic                    w_hit;
  logic [SEL_W-1:0]        w_sel;
  logic [TW-1:0]           w_timer_inc;
  logic [DATA_WIDTH-1:0]   w_slave_words [NUM_SLAVES];
  logic                    w_unused;

  // Only the tag byte takes part in decoding; the low word-address bits belong
  // to the slaves.
  assign w_unused = ^address[21:0];

  bus_tag_match #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_TAGS (SLAVE_TAGS)
  ) u_tag_match (
    .i_tag (address[29:22]),
    .o_hit (w_hit),
    .o_sel (w_sel)
  );

  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_words
      assign w_slave_words[gi] = slave_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign w_timer_inc = r_timer + TW'(1);

  // Access FSM with registered chip selects, read data, handshake and error count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_is_read   <= 1'b0;
      r_cs        <= '0;
      r_data      <= '0;
      r_ready     <= 1'b0;
      r_bus_error <= 1'b0;
      r_err_count <= '0;
      r_timer     <= '0;
    end else begin
      r_ready     <= 1'b0;
      r_bus_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The core still holds the finished request while ready is high,
          // so a new request is only taken once the pulse has gone.
          if (!r_ready) begin
            if (read && write) begin
              r_state <= ST_ERROR;
            end else if (read || write) begin
              if (w_hit) begin
                r_sel     <= w_sel;
                r_is_read <= read;
                r_cs      <= NUM_SLAVES'(1) << w_sel;
                r_timer   <= '0;
                r_state   <= ST_ACCESS;
              end else begin
                r_state <= ST_ERROR;
              end
            end
          end
        end
        ST_ACCESS: begin
          // A ready in the final timeout cycle still completes the access.
          if (slave_ready[r_sel]) begin
            if (r_is_read) r_data <= w_slave_words[r_sel];
            r_ready <= 1'b1;
            r_cs    <= '0;
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else if (TIMEOUT_EN && (w_timer_inc == TW'(TIMEOUT_CYCLES))) begin
            r_cs    <= '0;
            r_timer <= '0;
            r_state <= ST_ERROR;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        ST_ERROR: begin
          r_ready     <= 1'b1;
          r_bus_error <= 1'b1;
          if (r_err_count != {COUNT_WIDTH{1'b1}}) r_err_count <= r_err_count + COUNT_WIDTH'(1);
          r_state     <= ST_IDLE;
        end
        default: begin
          r_cs    <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign slave_cs    = r_cs;
  assign data_in     = r_data;
  assign ready       = r_ready;
  assign bus_error   = r_bus_error;
  assign error_count = r_err_count;

endmodule

// File: tb/tb_bus_decoder.sv
// Directed bench for bus_decoder with a scoreboard of expected completions.
module tb_bus_decoder;

  localparam int NS = 2;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [29:0]     address = '0;
  logic            read = 1'b0;
  logic            write = 1'b0;
  logic [NS*32-1:0] slave_data = '0;
  logic [NS-1:0]   slave_ready = '0;
  logic [NS-1:0]   slave_cs;
  logic [31:0]     data_in;
  logic            ready;
  logic            bus_error;
  logic [7:0]      error_count;

  int tests = 0;
  int fails = 0;
  int ntxn  = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_data = '0;
  logic [7:0]  exp_cnt  = '0;

  bus_decoder #(
    .NUM_SLAVES     (NS),
    .SLAVE_TAGS     ({8'hff, 8'h00}),
    .TIMEOUT_CYCLES (16),
    .COUNT_WIDTH    (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .slave_data  (slave_data),
    .slave_ready (slave_ready),
    .slave_cs    (slave_cs),
    .data_in     (data_in),
    .ready       (ready),
    .bus_error   (bus_error),
    .error_count (error_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Queue the completion the next request should produce.
  task automatic expect_txn(input logic err_v);
    exp_t e;
    e.data = exp_data;
    e.err  = err_v;
    sb.push_back(e);
    if (err_v && exp_cnt != 8'hff) exp_cnt++;
  endtask

  // Scoreboard: every ready pulse is matched against the oldest expectation.
  always @(negedge clock) begin
    if (ready === 1'b1) begin
      ntxn++;
      $display("[TB] txn %0d: data_in=%08h bus_error=%0b error_count=%0d",
               ntxn, data_in, bus_error, error_count);
      if (sb.size() == 0) begin
        chk("spurious_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_in", data_in, e.data);
        chk("bus_error", 32'(bus_error), 32'(e.err));
      end
    end else if (bus_error !== 1'b0) begin
      chk("error_without_ready", 32'(bus_error), 32'd0);
    end
  end

  // Drive one request; assert slave_ready on ACCESS cycle waits+1 (rslave<0: never).
  task automatic txn(input logic [29:0] a, input logic rd, input logic wr,
                     input int rslave, input int waits,
                     input logic [NS-1:0] exp_cs, input int exp_cs_cyc, input int exp_lat);
    int cs_cyc;
    int lat;
    cs_cyc = 0;
    lat    = 0;
    address     = a;
    read        = rd;
    write       = wr;
    slave_ready = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      slave_ready = '0;
      if (rslave >= 0 && k == waits + 1) slave_ready[rslave] = 1'b1;
      @(negedge clock);
      if (slave_cs !== '0) begin
        cs_cyc++;
        chk("slave_cs", 32'(slave_cs), 32'(exp_cs));
      end
      if (ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("latency", lat, exp_lat);
    chk("cs_cycles", cs_cyc, exp_cs_cyc);
    @(posedge clock); #1;
    read        = 1'b0;
    write       = 1'b0;
    slave_ready = '0;
  endtask

  initial begin
    slave_data = {32'hcafef00d, 32'hdeadbeef};

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cs", 32'(slave_cs), 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_error_count", 32'(error_count), 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Read 0x00000010, slave0 zero-wait
    exp_data = 32'hdeadbeef;
    expect_txn(1'b0);
    txn(30'h0000004, 1'b1, 1'b0, 0, 0, 2'b01, 1, 2);

    // Write 0xff000000, slave1 after 3 wait cycles; data_in must hold
    expect_txn(1'b0);
    txn(30'h3fc00000, 1'b0, 1'b1, 1, 3, 2'b10, 4, 5);

    // Unmapped read 0x12000000
    expect_txn(1'b1);
    txn(30'h04800000, 1'b1, 1'b0, -1, 0, 2'b00, 0, 2);
    @(negedge clock);
    chk("count_after_miss", 32'(error_count), 32'(exp_cnt));

    // Slave0 never ready: 16-cycle timeout then error
    expect_txn(1'b1);
    txn(30'h0000000, 1'b1, 1'b0, -1, 0, 2'b01, 16, 18);
    @(negedge clock);
    chk("count_after_timeout", 32'(error_count), 32'(exp_cnt));

    // Ready on exactly the 16th ACCESS cycle completes normally
    slave_data[31:0] = 32'h13579bdf;
    exp_data = 32'h13579bdf;
    expect_txn(1'b0);
    txn(30'h0000000, 1'b1, 1'b0, 0, 15, 2'b01, 16, 17);
    @(negedge clock);
    chk("count_after_late_ready", 32'(error_count), 32'(exp_cnt));

    // read and write together is a protocol error
    expect_txn(1'b1);
    txn(30'h0000000, 1'b1, 1'b1, -1, 0, 2'b00, 0, 2);
    @(negedge clock);
    chk("count_after_rw", 32'(error_count), 32'(exp_cnt));

    // 300 back-to-back errors saturate the counter
    for (int n = 0; n < 300; n++) begin
      expect_txn(1'b1);
      txn(30'h04800000, 1'b1, 1'b0, -1, 0, 2'b00, 0, 2);
    end
    @(negedge clock);
    chk("count_saturated", 32'(error_count), 32'hff);

    // Reset in the middle of an access
    address     = 30'h0000000;
    read        = 1'b1;
    slave_ready = '0;
    @(posedge clock); #1;
    @(posedge clock); #3;
    chk("cs_before_reset", 32'(slave_cs), 32'h1);
    reset = 1'b0;
    #1;
    chk("cs_async_reset", 32'(slave_cs), 32'd0);
    chk("ready_async_reset", 32'(ready), 32'd0);
    chk("count_async_reset", 32'(error_count), 32'd0);
    read     = 1'b0;
    exp_data = '0;
    exp_cnt  = '0;
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("data_after_reset", data_in, 32'd0);

    // Normal access after reset release, slave1 zero-wait
    exp_data = 32'hcafef00d;
    expect_txn(1'b0);
    txn(30'h3fc00001, 1'b1, 1'b0, 1, 0, 2'b10, 1, 2);
    @(negedge clock);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
